// File: rtl/fetch_stage_pkg.sv
// Shared pipeline package: fetch FSM states, instruction constants and PC helper.
package fetch_stage_pkg;

  localparam int INSTR_W = 16;

  localparam logic [INSTR_W-1:0] RESET_PC    = 16'h0000;
  localparam logic [INSTR_W-1:0] NOP_INSTR   = 16'h0000;
  localparam logic [3:0]         HALT_OPCODE = 4'hF;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

  // Next sequential fetch address; wraps modulo 2^16 and keeps bit 0 clear.
  function automatic logic [INSTR_W-1:0] next_pc(input logic [INSTR_W-1:0] pc);
    return (pc + 16'd2) & 16'hFFFE;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: hazard/branch controls in, instruction memory, IF/ID register out.
interface fetch_stage_if;
  import fetch_stage_pkg::*;

  logic               stall;
  logic               flush;
  logic [INSTR_W-1:0] target;
  logic [INSTR_W-1:0] imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic [INSTR_W-1:0] if_id_instr;
  logic [INSTR_W-1:0] if_id_pc2;
  logic               if_id_valid;
  logic               halted;

  // The fetch stage itself.
  modport master (
    input  stall, flush, target, imem_rdata,
    output imem_addr, if_id_instr, if_id_pc2, if_id_valid, halted
  );

  // Surrounding pipeline / memory.
  modport slave (
    output stall, flush, target, imem_rdata,
    input  imem_addr, if_id_instr, if_id_pc2, if_id_valid, halted
  );

endinterface

// File: rtl/fetch_perf_counters.sv
// Saturating flush/stall event counters for the fetch stage.
module fetch_perf_counters (
  input  logic        clk,
  input  logic        rst,
  input  logic        count_flush,
  input  logic        count_stall,
  output logic [15:0] flush_cnt,
  output logic [15:0] stall_cnt
);

  logic [15:0] flush_cnt_q, flush_cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Increment on event, pinning at all-ones instead of wrapping.
  always_comb begin
    flush_cnt_d = flush_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (count_flush && (flush_cnt_q != 16'hFFFF)) flush_cnt_d = flush_cnt_q + 16'd1;
    if (count_stall && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  // Counter registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      flush_cnt_q <= 16'h0000;
      stall_cnt_q <= 16'h0000;
    end else begin
      flush_cnt_q <= flush_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign flush_cnt = flush_cnt_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, imem address, IF/ID register, HALT handling.
// Optional feature macro: FETCH_PERF_CNT_EN adds flush_cnt/stall_cnt ports.
module fetch_stage
  import fetch_stage_pkg::*;
(
  input  logic clk,
  input  logic rst,
  fetch_stage_if.master bus
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0] flush_cnt,
  output logic [15:0] stall_cnt
`endif
);

  fetch_state_e       state_q, state_d;
  logic [INSTR_W-1:0] pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [INSTR_W-1:0] pc2_q, pc2_d;
  logic               valid_q, valid_d;

  // Next-state and IF/ID update; flush outranks stall, stall outranks fetch.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pc2_d   = pc2_q;
    valid_d = valid_q;
    case (state_q)
      ST_BOOT: begin
        // One idle cycle after reset; nothing captured.
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (bus.flush) begin
          pc_d    = bus.target & 16'hFFFE;
          instr_d = NOP_INSTR;
          pc2_d   = 16'h0000;
          valid_d = 1'b0;
        end else if (!bus.stall) begin
          instr_d = bus.imem_rdata;
          pc2_d   = next_pc(pc_q);
          valid_d = 1'b1;
          if (bus.imem_rdata[15:12] == HALT_OPCODE) begin
            // HALT goes down the pipe; PC stays parked on it.
            state_d = ST_HALT;
          end else begin
            pc_d = next_pc(pc_q);
          end
        end
      end
      ST_HALT: begin
        if (bus.flush) begin
          // The HALT was on the wrong path: resume at the redirect target.
          state_d = ST_RUN;
          pc_d    = bus.target & 16'hFFFE;
          instr_d = NOP_INSTR;
          pc2_d   = 16'h0000;
          valid_d = 1'b0;
        end else if (!bus.stall) begin
          // Feed bubbles so the HALT is delivered exactly once.
          instr_d = NOP_INSTR;
          pc2_d   = 16'h0000;
          valid_d = 1'b0;
        end
      end
      default: state_d = ST_BOOT;
    endcase
  end

  // State and IF/ID registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      pc2_q   <= 16'h0000;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc2_q   <= pc2_d;
      valid_q <= valid_d;
    end
  end

  assign bus.imem_addr   = pc_q;
  assign bus.if_id_instr = instr_q;
  assign bus.if_id_pc2   = pc2_q;
  assign bus.if_id_valid = valid_q;
  assign bus.halted      = (state_q == ST_HALT);

`ifdef FETCH_PERF_CNT_EN
  logic count_flush;
  logic count_stall;

  assign count_flush = bus.flush && (state_q != ST_BOOT);
  assign count_stall = bus.stall && !bus.flush;

  fetch_perf_counters u_perf (
    .clk         (clk),
    .rst         (rst),
    .count_flush (count_flush),
    .count_stall (count_stall),
    .flush_cnt   (flush_cnt),
    .stall_cnt   (stall_cnt)
  );
`endif

endmodule
